// File: rtl/pipe_mux_reg.sv
// Registered N-input pipeline selector with stall/flush control and
// out-of-range select detection feeding a saturating error counter.
module pipe_mux_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NUM_IN    = 3,
  parameter int unsigned      SEL_W     = 2,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int unsigned      ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        y,
  output logic                    y_valid,
  output logic [SEL_W-1:0]        y_sel,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic             sel_ok_c;
  logic [WIDTH-1:0] mux_c;

  // Select decode; an out-of-range select falls through to FLUSH_VAL.
  always_comb begin
    sel_ok_c = (32'(sel) < NUM_IN);
    mux_c    = FLUSH_VAL;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(sel) == k) mux_c = in_bus[k*WIDTH +: WIDTH];
    end
  end

  // Flush beats stall beats load; sel_err is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= FLUSH_VAL;
      y_valid <= 1'b0;
      y_sel   <= '0;
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else if (flush) begin
      y       <= FLUSH_VAL;
      y_valid <= 1'b0;
      y_sel   <= '0;
      sel_err <= 1'b0;
    end else if (stall) begin
      sel_err <= 1'b0;
    end else if (in_valid) begin
      if (sel_ok_c) begin
        y       <= mux_c;
        y_valid <= 1'b1;
        y_sel   <= sel;
        sel_err <= 1'b0;
      end else begin
        y       <= FLUSH_VAL;
        y_valid <= 1'b0;
        sel_err <= 1'b1;
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end else begin
      y_valid <= 1'b0;
      sel_err <= 1'b0;
    end
  end

endmodule

// File: doc/pipe_mux_reg.md
Name: pipe_mux_reg

Overview:
Parametrised, registered N-input datapath selector for the MIPS pipeline, e.g. next-PC source select: PC+4, branch target, jump target.
- Generalises the plain 2:1 32-bit MUX in four ways: configurable width and input count, one-cycle registered output, stall/flush pipeline control, and out-of-range select detection.
- Sits at a stage boundary; its output feeds the next stage directly.

Parameters:
WIDTH, 32, data width per input and of output.
NUM_IN, 3, number of inputs (2..16).
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
FLUSH_VAL, 32'h00000000, value loaded into y on reset/flush/select error (WIDTH bits).
ERR_CNT_W, 8, width of saturating error counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_bus  input  NUM_IN*WIDTH  concatenated inputs; input k = in_bus[k*WIDTH +: WIDTH].
sel  input  SEL_W  input select.
in_valid  input  1  sel/in_bus valid this cycle.
stall  input  1  hold all registered state.
flush  input  1  kill output, insert bubble.
y  output  WIDTH  registered selected data.
y_valid  output  1  y holds a valid selection.
y_sel  output  SEL_W  index that produced current y.
sel_err  output  1  one-cycle pulse: last load attempt used sel >= NUM_IN.
err_cnt  output  ERR_CNT_W  saturating count of select errors.

Behaviour:
Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- rst_n low (any time, no clock needed): y=FLUSH_VAL, y_valid=0, y_sel=0, sel_err=0, err_cnt=0. An in-flight selection is discarded.
- Latency: exactly 1 cycle. Inputs sampled at posedge N appear on y after posedge N.

Per-posedge priority, highest first:
1. flush=1 (overrides stall): y=FLUSH_VAL, y_valid=0, y_sel=0, sel_err=0; err_cnt unchanged.
2. stall=1: y, y_valid, y_sel, err_cnt hold; sel_err=0 (the pulse never stretches); inputs ignored.
3. in_valid=1 and sel<NUM_IN: y=input[sel], y_valid=1, y_sel=sel, sel_err=0.
4. in_valid=1 and sel>=NUM_IN: y=FLUSH_VAL, y_valid=0, y_sel holds, sel_err=1, err_cnt+=1, saturating at all-ones (no wrap).
5. in_valid=0: y_valid=0, y and y_sel hold, sel_err=0.

Rules:
- Comparison sel<NUM_IN is unsigned.
- If NUM_IN == 2**SEL_W, the error path is unreachable and sel_err stays 0.
- No combinational path from any input to any output.
- A select that is X/Z in simulation is a bench error; RTL behaviour for it is unspecified.
- Simultaneous flush+in_valid with a bad sel: flush wins; no error is counted.

Test Plan:
1. Reset/defaults: rst_n=0 mid-cycle with y=32'h1234 -> immediately y=0, y_valid=0, err_cnt=0, no clock edge required.
2. Select each input: in_bus={32'hCCCCCCCC,32'h55555555,32'hAAAAAAAA}, in_valid=1; sel=0,1,2 on successive cycles -> y=AAAAAAAA, 55555555, CCCCCCCC one cycle later each; y_valid=1; y_sel tracks sel.
3. Stall hold: after y=55555555 assert stall 3 cycles while sel=2 and inputs change to FFFFFFFF -> y stays 55555555, y_valid=1; release stall -> next cycle y = current input[2].
4. Flush priority: stall=1, flush=1, in_valid=1 together -> y=0, y_valid=0 after the edge; the next unstalled load resumes normally.
5. Out-of-range: NUM_IN=3, sel=3, in_valid=1 -> y=0, y_valid=0, sel_err=1 for exactly one cycle, err_cnt=1.
   - Repeat 300 cycles with ERR_CNT_W=8 -> err_cnt saturates at 8'hFF.
6. Bubble: in_valid=0 after y=A5A5A5A5 -> y_valid=0, y holds A5A5A5A5, sel_err=0.
